aes_key_sched_param: RTL and testbench
======================================

// Module: aes_key_sched_param
// PURPOSE
//  Parametrised AES key schedule: expands a 128/192/256-bit cipher key into all round keys.
//  Generates one 32-bit word per cycle, stores every round key, and serves registered
//  128-bit round-key reads by index. Successor to the fixed AES-128 key generator.
//  Sits between the key-load interface and the round datapath.
// PARAMETERS
//  KEY_BITS  128  cipher key length: 128, 192 or 256; any other value -> $error at elaboration
//  NK        KEY_BITS/32 (localparam)  key words: 4/6/8
//  NR        NK+6 (localparam)  rounds: 10/12/14
//  NW        4*(NR+1) (localparam)  schedule words: 44/52/60
// PORTS
//  clk       in   1         clock; all logic on the rising edge
//  rst       in   1         synchronous reset, active-high
//  key_in    in   KEY_BITS  cipher key; [KEY_BITS-1 -: 8] is byte 0 (FIPS-197 order)
//  key_load  in   1         1-cycle pulse; samples key_in and starts expansion
//  rk_rd_en  in   1         round-key read request
//  rk_index  in   4         round number, 0..NR
//  busy      out  1         expansion in progress
//  keys_valid out 1         all NR+1 round keys stored and readable
//  round_key out  128       registered read data; w[4r] in bits [127:96]
//  rk_valid  out  1         round_key valid this cycle (1-cycle pulse)
//  rk_err    out  1         read rejected (1-cycle pulse)
// BEHAVIOUR
//  - Reset: busy=0, keys_valid=0, round_key=0, rk_valid=0, rk_err=0, FSM=IDLE,
//    word counter=0, Rcon=8'h01. Word store is not cleared.
//  - FSM: IDLE --key_load--> LOAD --> EXPAND --(i==NW-1 written)--> DONE. DONE --key_load--> LOAD.
//  - LOAD: one cycle; w[0..NK-1] <= key_in; i <= NK; Rcon <= 8'h01; busy=1; keys_valid=0.
//  - EXPAND: one word per cycle, temp=w[i-1]:
//    i%NK==0: temp=SubWord(RotWord(temp)) ^ {Rcon,24'h0}; then Rcon <= xtime(Rcon)
//    (8'h80 -> 8'h1B).
//    NK==8 && i%NK==4: temp=SubWord(temp). w[i] <= w[i-NK]^temp; i <= i+1.
//  - Latency from key_load to keys_valid=1: 1+NW-NK+1 cycles = 42/48/54.
//    busy drops on the same edge keys_valid rises.
//  - S-box: combinational, 4 instances (one per SubWord byte); no other S-box use.
//  - Read: rk_rd_en sampled at edge N; at N+1 round_key = {w[4r],w[4r+1],w[4r+2],w[4r+3]}
//    and rk_valid=1. When keys_valid=0 or rk_index>NR: rk_err=1, rk_valid=0,
//    round_key=0. round_key otherwise holds its last value.
//  - key_load while busy: abort and restart at LOAD with the new key; the old schedule is lost.
//  - key_load and rk_rd_en on the same edge with keys_valid=1: the read returns the old key's round key.
//  - rst mid-expansion: immediate return to IDLE. Reads are rejected until a new key_load completes.
// CONFIGURATION
//  AES_KS_DEC_ORDER_EN defined: extra input dec_mode (1 bit).
//    When dec_mode=1, a read of rk_index r returns round key NR-r, for decryption sequencing.
//    Range/valid checks apply to r before mapping.
//  Not defined: dec_mode port absent; rk_index maps directly.
// TESTING
//  1 KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c
//    -> keys_valid after 42 cycles; idx0 = key; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
//  2 KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b
//    -> idx12 = e98ba06f448c773c8ecc720401002202 after 48 cycles.
//  3 KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4
//    -> idx14 = fe4890d1e6188d0b046df344706c631e after 54 cycles.
//  4 Read idx 11 with 128-bit key, and any read during busy
//    -> rk_err=1, rk_valid=0, round_key=0 next cycle.
//  5 key_load of key A, then key B 10 cycles later
//    -> keys_valid 42 cycles after B; idx10 matches key B's schedule; rst at cycle 20 -> busy=0, reads err.
//  6 AES_KS_DEC_ORDER_EN, 128-bit, dec_mode=1, idx0
//    -> d014f9a8c9ee2589e13f0cc8b6630ca6; idx10 -> key.

Source files
------------

// File: rtl/aes_key_sched_param.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_param
// Description : AES-128/192/256 key schedule, one word per cycle, with a
//               registered 128-bit round-key read port.
//               Optional macro AES_KS_DEC_ORDER_EN adds dec_mode (reversed
//               round-key order for decryption).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched_param #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_load,
    input  logic                rk_rd_en,
    input  logic [3:0]          rk_index,
`ifdef AES_KS_DEC_ORDER_EN
    input  logic                dec_mode,
`endif
    output logic                busy,
    output logic                keys_valid,
    output logic [127:0]        round_key,
    output logic                rk_valid,
    output logic                rk_err
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [5:0] c_nk    = 6'(NK);
    localparam logic [5:0] c_last  = 6'(NW - 1);
    localparam logic [2:0] c_nk_m1 = 3'(NK - 1);
    localparam logic [3:0] c_nr    = 4'(NR);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_key_bits_bad
            $error("aes_key_sched_param: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EXPAND = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int n = 1; n < 8; n++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    state_t       r_state_q, w_state_d;
    logic [5:0]   r_i_q, w_i_d;
    logic [2:0]   r_k_q, w_k_d;
    logic [7:0]   r_rcon_q, w_rcon_d;
    logic         r_busy_q, w_busy_d;
    logic         r_kv_q, w_kv_d;
    logic [127:0] r_rk_q, w_rk_d;
    logic         r_rv_q, w_rv_d;
    logic         r_re_q, w_re_d;
    logic [31:0]  r_words_q [NW];

    logic [31:0]  w_prev, w_back, w_sub_in, w_sub_out, w_temp, w_new;
    logic         w_load_we, w_exp_we, w_rd_ok;
    logic [3:0]   w_idx_eff;
    logic [5:0]   w_base;

    assign w_prev   = r_words_q[r_i_q - 6'd1];
    assign w_back   = r_words_q[r_i_q - c_nk];
    assign w_sub_in = (r_k_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    generate
        for (genvar gb = 0; gb < 4; gb++) begin : g_sbox
            assign w_sub_out[8*gb +: 8] = sbox(w_sub_in[8*gb +: 8]);
        end
    endgenerate

    always_comb begin
        w_temp = w_prev;
        if (r_k_q == 3'd0)
            w_temp = w_sub_out ^ {r_rcon_q, 24'h000000};
        else if (NK == 8 && r_k_q == 3'd4)
            w_temp = w_sub_out;
        w_new = w_back ^ w_temp;
    end

    always_comb begin
        w_state_d = r_state_q;
        w_i_d     = r_i_q;
        w_k_d     = r_k_q;
        w_rcon_d  = r_rcon_q;
        w_busy_d  = r_busy_q;
        w_kv_d    = r_kv_q;
        w_load_we = 1'b0;
        w_exp_we  = 1'b0;
        case (r_state_q)
            S_LOAD: begin
                w_state_d = S_EXPAND;
                w_i_d     = c_nk;
                w_k_d     = 3'd0;
                w_rcon_d  = 8'h01;
            end
            S_EXPAND: begin
                w_exp_we = 1'b1;
                w_i_d    = r_i_q + 6'd1;
                w_k_d    = (r_k_q == c_nk_m1) ? 3'd0 : r_k_q + 3'd1;
                if (r_k_q == 3'd0)
                    w_rcon_d = {r_rcon_q[6:0], 1'b0} ^ (r_rcon_q[7] ? 8'h1b : 8'h00);
                if (r_i_q == c_last)
                    w_state_d = S_DONE;
            end
            S_DONE: begin
                w_busy_d = 1'b0;
                w_kv_d   = 1'b1;
            end
            default: ;
        endcase
        // A new key always wins, aborting any expansion in flight.
        if (key_load) begin
            w_state_d = S_LOAD;
            w_busy_d  = 1'b1;
            w_kv_d    = 1'b0;
            w_load_we = 1'b1;
            w_exp_we  = 1'b0;
        end
    end

    always_comb begin
        w_rd_ok = r_kv_q && (rk_index <= c_nr);
`ifdef AES_KS_DEC_ORDER_EN
        w_idx_eff = dec_mode ? (c_nr - rk_index) : rk_index;
`else
        w_idx_eff = rk_index;
`endif
        w_base = {w_idx_eff, 2'b00};
        w_rk_d = r_rk_q;
        w_rv_d = 1'b0;
        w_re_d = 1'b0;
        if (rk_rd_en) begin
            if (w_rd_ok) begin
                w_rv_d = 1'b1;
                w_rk_d = {r_words_q[w_base], r_words_q[w_base + 6'd1],
                          r_words_q[w_base + 6'd2], r_words_q[w_base + 6'd3]};
            end else begin
                w_re_d = 1'b1;
                w_rk_d = 128'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_i_q     <= 6'd0;
            r_k_q     <= 3'd0;
            r_rcon_q  <= 8'h01;
            r_busy_q  <= 1'b0;
            r_kv_q    <= 1'b0;
            r_rk_q    <= 128'h0;
            r_rv_q    <= 1'b0;
            r_re_q    <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_i_q     <= w_i_d;
            r_k_q     <= w_k_d;
            r_rcon_q  <= w_rcon_d;
            r_busy_q  <= w_busy_d;
            r_kv_q    <= w_kv_d;
            r_rk_q    <= w_rk_d;
            r_rv_q    <= w_rv_d;
            r_re_q    <= w_re_d;
        end
    end

    // Word store is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_load_we) begin
            for (int j = 0; j < NK; j++)
                r_words_q[j] <= key_in[KEY_BITS-1-32*j -: 32];
        end else if (w_exp_we) begin
            r_words_q[r_i_q] <= w_new;
        end
    end

    assign busy       = r_busy_q;
    assign keys_valid = r_kv_q;
    assign round_key  = r_rk_q;
    assign rk_valid   = r_rv_q;
    assign rk_err     = r_re_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_sched_param
// Description : Directed scoreboard bench for the 128/192/256-bit key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         rk_rd_en;
    logic [3:0]   rk_index;
`ifdef AES_KS_DEC_ORDER_EN
    logic         dec_mode;
`endif
    logic [127:0] key0;
    logic [191:0] key1;
    logic [255:0] key2;
    logic [2:0]   kl;
    logic [2:0]   busy, kv, rv, re;
    logic [127:0] rk [3];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic         err;
        logic [127:0] key;
    } exp_t;
    exp_t sb_q[$];

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A_R10= 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B_R10= 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [191:0] KEY_192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] K192_R12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] KEY_256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256_R14 = 128'hfe4890d1e6188d0b046df344706c631e;

    aes_key_sched_param #(.KEY_BITS(128)) u_k128 (
        .clk(clk), .rst(rst), .key_in(key0), .key_load(kl[0]),
        .rk_rd_en(rk_rd_en), .rk_index(rk_index),
`ifdef AES_KS_DEC_ORDER_EN
        .dec_mode(dec_mode),
`endif
        .busy(busy[0]), .keys_valid(kv[0]), .round_key(rk[0]),
        .rk_valid(rv[0]), .rk_err(re[0])
    );

    aes_key_sched_param #(.KEY_BITS(192)) u_k192 (
        .clk(clk), .rst(rst), .key_in(key1), .key_load(kl[1]),
        .rk_rd_en(rk_rd_en), .rk_index(rk_index),
`ifdef AES_KS_DEC_ORDER_EN
        .dec_mode(dec_mode),
`endif
        .busy(busy[1]), .keys_valid(kv[1]), .round_key(rk[1]),
        .rk_valid(rv[1]), .rk_err(re[1])
    );

    aes_key_sched_param #(.KEY_BITS(256)) u_k256 (
        .clk(clk), .rst(rst), .key_in(key2), .key_load(kl[2]),
        .rk_rd_en(rk_rd_en), .rk_index(rk_index),
`ifdef AES_KS_DEC_ORDER_EN
        .dec_mode(dec_mode),
`endif
        .busy(busy[2]), .keys_valid(kv[2]), .round_key(rk[2]),
        .rk_valid(rv[2]), .rk_err(re[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_compare(input int inst, input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 128'd1, 128'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".rk_valid"}, 128'(rv[inst]), 128'(!e.err));
            check({tag, ".rk_err"},   128'(re[inst]), 128'(e.err));
            check({tag, ".round_key"}, rk[inst], e.key);
        end
    endtask

    task automatic read(input int inst, input logic [3:0] idx, input logic err,
                        input logic [127:0] key, input string tag);
        sb_q.push_back({err, err ? 128'h0 : key});
        rk_rd_en = 1'b1;
        rk_index = idx;
        tick();
        rk_rd_en = 1'b0;
        pop_compare(inst, tag);
    endtask

    task automatic load(input int inst, input logic [255:0] k);
        if (inst == 0) key0 = k[127:0];
        if (inst == 1) key1 = k[191:0];
        if (inst == 2) key2 = k;
        kl[inst] = 1'b1;
        tick();
        kl = 3'b000;
    endtask

    task automatic wait_valid(input int inst, input int lat, input string tag);
        int cnt = 0;
        while (!kv[inst] && cnt < 200) begin
            tick();
            cnt++;
        end
        check(tag, 128'(cnt), 128'(lat));
    endtask

    initial begin
        rst = 1'b1; rk_rd_en = 1'b0; rk_index = 4'd0; kl = 3'b000;
        key0 = '0; key1 = '0; key2 = '0;
`ifdef AES_KS_DEC_ORDER_EN
        dec_mode = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("reset.busy", 128'(busy[0]), 128'd0);
        check("reset.keys_valid", 128'(kv[0]), 128'd0);
        check("reset.round_key", rk[0], 128'h0);
        check("reset.rk_valid", 128'(rv[0]), 128'd0);
        check("reset.rk_err", 128'(re[0]), 128'd0);
        read(0, 4'd0, 1'b1, 128'h0, "idle_read");

        // AES-128 reference key
        load(0, 256'(KEY_A));
        check("k128.busy_after_load", 128'(busy[0]), 128'd1);
        wait_valid(0, 42, "k128.latency");
        check("k128.busy_done", 128'(busy[0]), 128'd0);
        read(0, 4'd0,  1'b0, KEY_A,     "k128.idx0");
        read(0, 4'd1,  1'b0, KEY_A_R1,  "k128.idx1");
        read(0, 4'd10, 1'b0, KEY_A_R10, "k128.idx10");
        tick();
        check("k128.hold_key", rk[0], KEY_A_R10);
        check("k128.hold_valid", 128'(rv[0]), 128'd0);
        read(0, 4'd11, 1'b1, 128'h0, "k128.idx11");
        read(0, 4'd15, 1'b1, 128'h0, "k128.idx15");

        // AES-192
        load(1, 256'(KEY_192));
        wait_valid(1, 48, "k192.latency");
        read(1, 4'd12, 1'b0, K192_R12, "k192.idx12");
        read(1, 4'd0,  1'b0, 128'h8e73b0f7da0e6452c810f32b809079e5, "k192.idx0");
        read(1, 4'd13, 1'b1, 128'h0, "k192.idx13");

        // AES-256
        load(2, KEY_256);
        wait_valid(2, 54, "k256.latency");
        read(2, 4'd14, 1'b0, K256_R14, "k256.idx14");
        read(2, 4'd0,  1'b0, 128'h603deb1015ca71be2b73aef0857d7781, "k256.idx0");
        read(2, 4'd15, 1'b1, 128'h0, "k256.idx15");

        // Restart: key A, then key B ten cycles later; includes a read while busy
        load(0, 256'(KEY_A));
        read(0, 4'd5, 1'b1, 128'h0, "busy_read");
        repeat (8) tick();
        load(0, 256'(KEY_B));
        wait_valid(0, 42, "restart.latency");
        read(0, 4'd10, 1'b0, KEY_B_R10, "restart.idx10");
        read(0, 4'd0,  1'b0, KEY_B,     "restart.idx0");

        // Load and read on the same edge: read sees the previous schedule
        sb_q.push_back({1'b0, KEY_B_R10});
        key0 = KEY_A; kl[0] = 1'b1; rk_rd_en = 1'b1; rk_index = 4'd10;
        tick();
        kl = 3'b000; rk_rd_en = 1'b0;
        pop_compare(0, "same_edge");
        wait_valid(0, 42, "same_edge.latency");
        read(0, 4'd10, 1'b0, KEY_A_R10, "same_edge.new_idx10");

        // Reset mid-expansion
        load(0, 256'(KEY_B));
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.busy", 128'(busy[0]), 128'd0);
        check("midrst.keys_valid", 128'(kv[0]), 128'd0);
        read(0, 4'd0, 1'b1, 128'h0, "midrst.read");
        repeat (50) tick();
        check("midrst.stays_idle", 128'(kv[0]), 128'd0);

`ifdef AES_KS_DEC_ORDER_EN
        load(0, 256'(KEY_A));
        wait_valid(0, 42, "dec.latency");
        dec_mode = 1'b1;
        read(0, 4'd0,  1'b0, KEY_A_R10, "dec.idx0");
        read(0, 4'd10, 1'b0, KEY_A,     "dec.idx10");
        read(0, 4'd9,  1'b0, KEY_A_R1,  "dec.idx9");
        read(0, 4'd11, 1'b1, 128'h0,    "dec.idx11");
        dec_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
